// File: rtl/alu_sequencer_pkg.sv
// Shared CPU definitions: ALU opcodes, instruction field positions and the
// issue-controller state encoding.
package alu_sequencer_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_IMM_W  = 7;
  localparam int INSTR_W    = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Instruction layout: [15:14] op, [13:12] rd, [11:10] rs1, [9:8] rs2,
  // [7] use_imm, [6:0] imm
  localparam int F_OP_LSB  = 14;
  localparam int F_RD_LSB  = 12;
  localparam int F_RS1_LSB = 10;
  localparam int F_RS2_LSB = 8;
  localparam int F_USE_IMM = 7;
  localparam int F_IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus the operand/result bus to the external ALU.
interface alu_sequencer_if #(
  parameter int DATA_W = 16
);
  // instr_valid/instr_ready: an instruction transfers on a rising edge where
  // both are high. The source holds instr stable while valid is high and not
  // yet accepted; ready depends only on sequencer state, never on valid.
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport master (
    output instr_valid, instr, alu_result, alu_zero,
    input  instr_ready, alu_a, alu_b, alu_op
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_zero,
    output instr_ready, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_regfile.sv
// 4-entry register file: R0 hard-wired to zero, two read ports, a debug read
// port and one synchronous write port.
module alu_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ra1,
  input  logic [1:0]        ra2,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [1:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [4];

  // Entry 0 is only ever reset, so it stays a constant zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 2'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == 2'd0)      ? '0 : regs[ra1];
  assign rd2      = (ra2 == 2'd0)      ? '0 : regs[ra2];
  assign dbg_data = (dbg_addr == 2'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle issue controller: accepts an instruction, reads operands, drives
// the external ALU, captures its result and writes it back (4 cycles/instr).
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus,
  output logic              done,
  output logic              flag_z,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output state_t            dbg_state
);

  state_t             state, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  a_q, b_q, res_q;
  logic [1:0]         op_q;
  logic               z_q;
  logic               rf_we;

  logic [1:0]         f_op, f_rd, f_rs1, f_rs2;
  logic               f_use_imm;
  logic [IMM_W-1:0]   f_imm;
  logic [DATA_W-1:0]  imm_ext, rs1_data, rs2_data;

  assign f_op      = instr_q[F_OP_LSB  +: 2];
  assign f_rd      = instr_q[F_RD_LSB  +: 2];
  assign f_rs1     = instr_q[F_RS1_LSB +: 2];
  assign f_rs2     = instr_q[F_RS2_LSB +: 2];
  assign f_use_imm = instr_q[F_USE_IMM];
  assign f_imm     = instr_q[F_IMM_LSB +: IMM_W];
  assign imm_ext   = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};

  alu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (f_rs1),
    .ra2      (f_rs2),
    .dbg_addr (dbg_addr),
    .rd1      (rs1_data),
    .rd2      (rs2_data),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (f_rd),
    .wd       (res_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d         = state;
    bus.instr_ready = 1'b0;
    done            = 1'b0;
    rf_we           = 1'b0;
    case (state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        done    = 1'b1;
        rf_we   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; ALU operands change only when leaving READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      res_q   <= '0;
      z_q     <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.instr_valid) instr_q <= bus.instr;
        S_READ: begin
          a_q  <= rs1_data;
          b_q  <= f_use_imm ? imm_ext : rs2_data;
          op_q <= f_op;
        end
        S_EXEC: begin
          res_q <= bus.alu_result;
          z_q   <= bus.alu_zero;
        end
        S_WB:    flag_z <= z_q;
        default: ;
      endcase
    end
  end

  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;
  assign bus.alu_op = op_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a reference model predicts each
// instruction's operands, result and flag; a monitor checks them at done.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [1:0]  rd;
    logic [15:0] res;
    logic        z;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        done;
  logic        flag_z;
  logic [1:0]  dbg_addr;
  logic [15:0] dbg_data;
  state_t      dbg_state;

  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  exp_t        exp_q[$];
  int          ref_rf[4];
  logic [15:0] mon_rf[4];
  logic        mon_flag;

  alu_sequencer_if #(.DATA_W(16)) bus ();

  alu_sequencer #(.DATA_W(16), .IMM_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .done      (done),
    .flag_z    (flag_z),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // External two-bit-opcode ALU
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
    bus.alu_zero = (bus.alu_result == 16'h0000);
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int wrap16(input int v);
    return ((v % 65536) + 65536) % 65536;
  endfunction

  task automatic model_exec(input logic [15:0] ins, input int acc, output exp_t e);
    int op, rd, rs1, rs2, imm, a, b, r;
    op  = int'(ins[15:14]);
    rd  = int'(ins[13:12]);
    rs1 = int'(ins[11:10]);
    rs2 = int'(ins[9:8]);
    imm = int'(ins[6:0]);
    a = ref_rf[rs1];
    if (ins[7]) b = wrap16((imm >= 64) ? imm - 128 : imm);
    else        b = ref_rf[rs2];
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      default: r = a | b;
    endcase
    r = wrap16(r);
    if (rd != 0) ref_rf[rd] = r;
    e.a   = 16'(a);
    e.b   = 16'(b);
    e.op  = 2'(op);
    e.rd  = 2'(rd);
    e.res = 16'(r);
    e.z   = (r == 0);
    e.acc = acc;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where the DUT is IDLE again.
  task automatic issue(input logic [15:0] ins, input bit hold);
    exp_t e;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    for (int w = 0; w < 20 && !bus.instr_ready; w++) @(negedge clk);
    if (!bus.instr_ready) begin
      check("accept_timeout", 32'(bus.instr_ready), 32'd1);
      bus.instr_valid = 1'b0;
      return;
    end
    model_exec(ins, cyc + 1, e);
    exp_q.push_back(e);
    @(negedge clk);
    if (!hold) bus.instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("ready_busy", 32'(bus.instr_ready), 32'd0);
      @(negedge clk);
    end
    check("ready_idle", 32'(bus.instr_ready), 32'd1);
  endtask

  task automatic reset_checks();
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flag_z", 32'(flag_z), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t it;
    exp_t pend_item;
    bit   pend;
    pend      = 1'b0;
    pend_item = '0;
    mon_flag  = 1'b0;
    dbg_addr  = 2'd0;
    for (int i = 0; i < 4; i++) mon_rf[i] = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) mon_rf[i] = 16'h0;
        mon_flag = 1'b0;
        pend     = 1'b0;
      end else begin
        // Write-back lands on the edge after done; commit it now.
        if (pend) begin
          if (pend_item.rd != 2'd0) mon_rf[pend_item.rd] = pend_item.res;
          mon_flag = pend_item.z;
          pend     = 1'b0;
        end
        check("dbg_data", 32'(dbg_data), 32'(mon_rf[dbg_addr]));
        check("flag_z", 32'(flag_z), 32'(mon_flag));
        if (done) begin
          if (exp_q.size() == 0) begin
            check("done_spurious", 32'(done), 32'd0);
          end else begin
            it = exp_q.pop_front();
            check("alu_a", 32'(bus.alu_a), 32'(it.a));
            check("alu_b", 32'(bus.alu_b), 32'(it.b));
            check("alu_op", 32'(bus.alu_op), 32'(it.op));
            check("done_latency", 32'(cyc - it.acc), 32'd2);
            pend_item = it;
            pend      = 1'b1;
          end
        end
        dbg_addr = dbg_addr + 2'd1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [15:0] rnd;
    bit          hold;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    reset_checks();
    repeat (5) @(negedge clk);

    // Directed: immediate add, self-subtract, sign-extended -1 and wrap
    issue(16'h1085, 1'b0);
    issue(16'h6500, 1'b0);
    issue(16'h30FF, 1'b0);
    issue(16'h3C81, 1'b0);
    repeat (2) @(negedge clk);
    check("r1_after_add", 32'(ref_rf[1]), 32'h0005);

    // Valid held high across two queued instructions, second targets R0
    issue(16'hD48A, 1'b1);
    issue(16'h4500, 1'b1);
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during EXEC aborts the in-flight write-back
    bus.instr       = 16'h1089;
    bus.instr_valid = 1'b1;
    check("pre_abort_ready", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    reset_checks();
    repeat (4) @(negedge clk);
    issue(16'h2480, 1'b0);

    // Randomized instructions, with and without valid held high
    for (int n = 0; n < 40; n++) begin
      rnd  = 16'($urandom_range(0, 65535));
      hold = 1'($urandom_range(0, 1));
      issue(rnd, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.instr_valid = 1'b0;

    repeat (6) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue controller that drives the 16-bit two-bit-opcode ALU from the operand side. It accepts one 16-bit instruction per valid/ready handshake, decodes it, and reads operands from a 4-entry register file. It presents `a`/`b`/`op` to the external ALU, captures `result`/`zero`, and writes the result back. It sits between the instruction source and the ALU and is the ALU's only driver.

## Interface
Parameters:
- DATA_W, 16, datapath width; must match the ALU.
- IMM_W, 7, immediate field width; sign-extended to DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  16  [15:14] op, [13:12] rd, [11:10] rs1, [9:8] rs2, [7] use_imm, [6:0] imm.
- alu_a  out  DATA_W  ALU operand a (registered).
- alu_b  out  DATA_W  ALU operand b (registered).
- alu_op  out  2  ALU opcode (registered): 00 ADD, 01 SUB, 10 AND, 11 OR.
- alu_result  in  DATA_W  ALU combinational result.
- alu_zero  in  1  ALU zero flag.
- done  out  1  one-cycle pulse during write-back.
- flag_z  out  1  sticky zero flag of the last completed instruction.
- dbg_addr  in  2  debug register read address.
- dbg_data  out  DATA_W  combinational read of the register at dbg_addr.

## Operation
- FSM states are IDLE, READ, EXEC and WB; there are no other states.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and go to READ.
- READ:
  - Load alu_a from R[rs1].
  - Load alu_b from use_imm ? sext(imm) : R[rs2].
  - Load alu_op from instr[15:14].
  - Go to EXEC.
- EXEC: ALU output is settled; capture alu_result into res_q and alu_zero into z_q; go to WB.
- WB:
  - done=1.
  - On the exiting edge, write R[rd]=res_q (discarded when rd=0) and set flag_z=z_q.
  - Go to IDLE.
- Register file:
  - 4 x DATA_W.
  - R0 reads 0 always; writes to R0 are discarded.
  - flag_z still updates on an rd=0 instruction.
- Arithmetic is modulo 2^DATA_W; there is no carry or overflow output. The sign extension of imm replicates bit 6.
- alu_a, alu_b and alu_op hold their values outside READ; they change only on the READ exit edge.
- instr_ready=0 in READ, EXEC and WB. instr_valid held during that time is ignored, not queued.
- Reset, whether idle or mid-operation:
  - State returns to IDLE and any in-flight instruction is aborted without write-back.
  - All registers, alu_a/alu_b/alu_op, res_q, flag_z and done reset to 0.
  - R1-R3 reset to 0.

## Timing
- Accept edge E0 leads to READ.
- E1: operands are registered; state is EXEC.
- E2: result is captured; state is WB and done=1 for exactly one cycle.
- E3: register file and flag_z are updated; state is IDLE and instr_ready=1.
- Throughput is one instruction per 4 cycles. The next accept is at the earliest E4, with E3→E4 spent in IDLE.
- dbg_data reflects a write from the cycle after E3.
- Operand read happens during READ, after the previous instruction has completed. There are no hazards and no forwarding.
- Reset values: instr_ready=1 after reset release, done=0, flag_z=0, alu_a=alu_b=0, alu_op=00, dbg_data=0.

## Structure
- Shared package/include `cpu_defs`:
  - Opcode constants OP_ADD, OP_SUB, OP_AND and OP_OR, shared with the ALU.
  - Instruction field positions.
  - FSM state encoding.
- Sub-module `alu_regfile`:
  - 4 x DATA_W registers with R0 fixed at zero.
  - Two combinational read ports plus the debug port.
  - One synchronous write port.
  - Asynchronous active-low reset.
- The FSM, instruction latch, immediate extension and result capture live in alu_sequencer.
- The ALU is instantiated by the bench or the top, not inside this block.

## Test plan
- Reset release → instr_ready=1, done=0, flag_z=0, alu_op=00, alu_a=alu_b=0, dbg_data=0 for all addresses.
- ADD R1=R0+imm 5 (instr 0x1085) → done exactly 2 cycles after the accept edge; R1=0x0005 and flag_z=0 after E3.
- SUB R2=R1-R1 (instr 0x6500) → R2=0x0000, flag_z=1.
- ADD R3=R0+imm 0x7F (−1) → R3=0xFFFF; then ADD R3=R3+imm 1 → R3=0x0000 (wrap), flag_z=1.
- instr_valid held high with 2 instructions queued at the source → accepts 4 cycles apart; instr_ready low in READ/EXEC/WB; a write to rd=0 leaves R0 at 0 but updates flag_z.
- rst_n asserted during EXEC of ADD R1=R0+imm 9 → R1 unchanged at 0, no done pulse; instr_ready=1 after release.
